ma_lsu: RTL

- Memory-access stage load/store unit. Sits between the EX pipeline register and the 4-byte-lane 1r1w data RAM (`data_1r1w`).
- Turns EX load/store requests into RAM read address, write address, write data and byte enables.
- Captures the registered RAM read data one cycle later, then aligns and sign/zero-extends it into a registered WB result.
- Detects misaligned, out-of-range and illegal-funct3 accesses, and handles pipeline stall and flush.

---
 rtl/ma_lsu_pkg.sv | 32 +++
 rtl/ma_load_align.sv | 25 ++
 rtl/ma_lsu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ma_lsu_pkg.sv
// Shared constants and types for the memory-access load/store unit.
// funct3 encodings follow RV32I; exception codes are what ma_exc_code reports.
package ma_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // One in-flight load waiting for its RAM read data.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ma_entry_t;

  function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         return (f3 > F3_SW);
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// Selects the addressed byte/halfword lane from a RAM word and sign- or
// zero-extends it according to the load funct3.
module ma_load_align
  import ma_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ma_lsu.sv
// Memory-access stage: drives the 1r1w data RAM for loads/stores, aligns the
// registered read data into a WB result and flags faulting accesses.
module ma_lsu
  import ma_lsu_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic [RAM_AW-1:0] ram_radr,
  input  logic [31:0]       ram_rdata,
  output logic [RAM_AW-1:0] ram_wadr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wen,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              ma_exc,
  output logic [1:0]        ma_exc_code,
  output logic [31:0]       ma_exc_addr
);

  logic        accept;
  logic [1:0]  off;
  logic [1:0]  err_code;
  logic        store_ok;
  logic        load_ok;
  logic [3:0]  store_mask;
  logic [31:0] load_data;

  ma_entry_t         ma_q, ma_d;
  logic [RAM_AW-1:0] radr_q, radr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              exc_q, exc_d;
  logic [1:0]        exc_code_q, exc_code_d;
  logic [31:0]       exc_addr_q, exc_addr_d;

  assign off    = ex_addr[1:0];
  assign accept = ex_valid & (ex_load | ex_store) & ~stall & ~flush & ~rst;

  // Illegal funct3 outranks misalignment, which outranks range.
  always_comb begin
    err_code = EXC_NONE;
    if (f3_illegal(ex_load, ex_funct3))
      err_code = EXC_ILLEGAL;
    else if ((ex_funct3[1:0] == 2'b01 && off[0]) || (ex_funct3[1:0] == 2'b10 && off != 2'b00))
      err_code = EXC_MISALIGN;
    else if (|ex_addr[31:RAM_AW+2])
      err_code = EXC_RANGE;
  end

  assign store_ok = accept & ex_store & (err_code == EXC_NONE);
  assign load_ok  = accept & ex_load  & (err_code == EXC_NONE);

  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        ram_wdata  = {4{ex_wdata[7:0]}};
        store_mask = 4'b0001 << off;
      end
      2'b01: begin
        ram_wdata  = {2{ex_wdata[15:0]}};
        store_mask = 4'b0011 << off;
      end
      default: begin
        ram_wdata  = ex_wdata;
        store_mask = 4'b1111;
      end
    endcase
  end

  assign ram_wen  = store_ok ? store_mask : 4'b0000;
  assign ram_wadr = ex_addr[RAM_AW+1:2];
  // While stalled the RAM keeps re-reading the in-flight word so rdata stays valid.
  assign ram_radr = (stall & ~flush) ? radr_q : ex_addr[RAM_AW+1:2];

  ma_load_align u_align (
    .funct3_i (ma_q.funct3),
    .off_i    (ma_q.off),
    .rdata_i  (ram_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    ma_d       = ma_q;
    radr_d     = radr_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush) begin
      ma_d.valid = 1'b0;
      wb_valid_d = 1'b0;
      radr_d     = ram_radr;
    end else if (!stall) begin
      ma_d.valid  = load_ok;
      ma_d.rd     = ex_rd;
      ma_d.funct3 = ex_funct3;
      ma_d.off    = off;
      radr_d      = ram_radr;
      wb_valid_d  = ma_q.valid;
      if (ma_q.valid) begin
        wb_rd_d   = ma_q.rd;
        wb_data_d = load_data;
      end
    end
    exc_d      = accept & (err_code != EXC_NONE);
    exc_code_d = exc_d ? err_code : exc_code_q;
    exc_addr_d = exc_d ? ex_addr  : exc_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_q       <= '0;
      radr_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= EXC_NONE;
      exc_addr_q <= '0;
    end else begin
      ma_q       <= ma_d;
      radr_q     <= radr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      exc_q      <= exc_d;
      exc_code_q <= exc_code_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign ma_exc      = exc_q;
  assign ma_exc_code = exc_code_q;
  assign ma_exc_addr = exc_addr_q;

endmodule
